// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-cycle controller around a combinational single-step
//            shifter. It runs 0 to 2^CNT_W-1 single-bit shift steps and
//            presents a registered result with a sticky overflow flag through
//            a start/busy/done handshake.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request a new shift; sampled only while idle
//   data_in   in   [WIDTH]  operand captured on an accepted start
//   dir       in   direction: 0 = left, 1 = right
//   amount    in   [CNT_W]  number of single-bit steps
//   sh_a      out  [WIDTH]  operand to the shifter (work register)
//   sh_sel    out  direction select to the shifter (latched dir)
//   sh_out    in   [WIDTH]  shifter result for the current sh_a/sh_sel
//   sh_ovf    in   shifter overflow for the current step
//   busy      out  high from accepted start through the done cycle
//   done      out  one-cycle pulse; result/overflow are valid from here on
//   result    out  [WIDTH]  registered final shift result
//   overflow  out  sticky OR of sh_ovf over every step of the operation
// ============================================================================
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] sh_a,
  output logic             sh_sel,
  input  logic [WIDTH-1:0] sh_out,
  input  logic             sh_ovf,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic             sel;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;

  // The shifter sees only registered values, so there is no combinational
  // path from start/data_in to the shifter inputs.
  assign sh_a   = work;
  assign sh_sel = sel;

  // result/overflow are loaded on the edge that enters FINISH, which is the
  // same edge that raises done, so they are valid throughout the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      work     <= '0;
      sel      <= 1'b0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work    <= data_in;
            sel     <= dir;
            cnt     <= amount;
            ovf_acc <= 1'b0;
            busy    <= 1'b1;
            if (amount != '0) begin
              state <= SHIFT;
            end else begin
              // Zero-length shift: the operand is the answer, no steps taken.
              state    <= FINISH;
              done     <= 1'b1;
              result   <= data_in;
              overflow <= 1'b0;
            end
          end
        end

        SHIFT: begin
          work    <= sh_out;
          ovf_acc <= ovf_acc | sh_ovf;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            // Last step: take the shifter output directly so the result is
            // ready together with done.
            state    <= FINISH;
            done     <= 1'b1;
            result   <= sh_out;
            overflow <= ovf_acc | sh_ovf;
          end
        end

        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
